// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - PS/2 keyboard-side transmitter with byte FIFO and host-inhibit handling
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 2000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [4:0] fifo_count
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [16:0] HALF_LAST = 17'(CLK_DIV - 1);
  localparam logic [16:0] GAP_LAST  = 17'(2 * CLK_DIV - 1);
  localparam logic [4:0]  DEPTH     = 5'(FIFO_DEPTH);
  localparam logic [3:0]  STOP_IDX  = 4'd10;

  typedef enum logic [2:0] {IDLE, HIGH, LOW, HOLD, GAP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [16:0]   cnt;
  logic          push;
  logic          pop;
  logic          abort;

  assign kbd_ready = (fifo_count != DEPTH);
  assign push      = kbd_valid && kbd_ready;
  assign pop       = (state == LOW) && (cnt == HALF_LAST) && (bit_idx == STOP_IDX);
  // Once the stop bit is on the wire the host can no longer abort the frame.
  assign abort     = inhibit && (bit_idx != STOP_IDX) && ((state == HIGH) || (state == LOW));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= kbd_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // frame[k] holds wire bit k+1; the start bit is driven directly on leaving IDLE.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
      frame    <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
    end else if (abort) begin
      state    <= HOLD;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      bit_idx  <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((fifo_count != 5'd0) && !inhibit) begin
            frame    <= {1'b1, ~^mem[rd_ptr], mem[rd_ptr]};
            ps2_data <= 1'b0;
            ps2_clk  <= 1'b1;
            bit_idx  <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            ps2_clk <= 1'b0;
            state   <= LOW;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        LOW: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            ps2_clk <= 1'b1;
            if (bit_idx != STOP_IDX) begin
              ps2_data <= frame[bit_idx];
              bit_idx  <= bit_idx + 4'd1;
              state    <= HIGH;
            end else begin
              ps2_data <= 1'b1;
              bit_idx  <= '0;
              state    <= GAP;
            end
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        HOLD: begin
          if (!inhibit) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        default: begin
          state    <= IDLE;
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          busy     <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb/tb_ps2_kbd_tx.sv - self-checking bench for ps2_kbd_tx
// A line monitor decodes frames from ps2_clk/ps2_data and compares them with a byte-level model.
module tb_ps2_kbd_tx;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ready;
  logic       inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [4:0] fifo_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  int          nbits = 0;
  int          hi_run = 0;
  int          lo_run = 0;
  int          falls = 0;
  int          last_lead = 0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  logic [10:0] cur = '0;
  logic [10:0] last_bits = '0;
  logic [10:0] mon_exp;

  ps2_kbd_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .kbd_data   (kbd_data),
    .kbd_valid  (kbd_valid),
    .kbd_ready  (kbd_ready),
    .inhibit    (inhibit),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit 0 is first on the wire).
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!n_reset) begin
      nbits  = 0;
      hi_run = 0;
      lo_run = 0;
    end else begin
      if (ps2_data !== prev_data) chk("data_change_clk_high", 32'(ps2_clk), 32'd1);
      if (prev_clk && !ps2_clk) begin
        falls++;
        if (nbits == 0) last_lead = hi_run;
        else chk("high_half_period", 32'(hi_run), 32'(D));
        cur[nbits] = ps2_data;
        nbits++;
        hi_run = 0;
        if (nbits == 11) begin
          mon_exp = frame_bits(cur[8:1]);
          chk("start_bit", 32'(cur[0]), 32'd0);
          chk("parity_bit", 32'(cur[9]), 32'(mon_exp[9]));
          chk("stop_bit", 32'(cur[10]), 32'd1);
          last_bits = cur;
          rx_q.push_back(cur[8:1]);
          nbits = 0;
        end
      end else if (!prev_clk && ps2_clk) begin
        chk("low_half_period", 32'(lo_run), 32'(D));
        lo_run = 0;
      end
      if (ps2_clk) begin
        hi_run++;
        if (hi_run > D && nbits != 0) nbits = 0;
      end else begin
        lo_run++;
      end
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    kbd_data  = b;
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
  endtask

  task automatic wait_bit(input int n);
    int t;
    t = 0;
    while (!(nbits == n && ps2_clk === 1'b1) && t < 3000) begin
      tick();
      t++;
    end
    chk("wait_bit_in_time", 32'(t < 3000), 32'd1);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (!(rx_q.size() >= exp_q.size() && busy === 1'b0 && fifo_count === 5'd0) && t < 6000) begin
      tick();
      t++;
    end
    chk({tag, "_drain_in_time"}, 32'(t < 6000), 32'd1);
    chk({tag, "_frame_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_byte_order"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          f0;
    int          cyc;
    int          t;
    int          n;
    logic [7:0]  b;
    logic [7:0]  five [5];
    logic [10:0] ef;

    n_reset   = 1'b0;
    kbd_data  = 8'h00;
    kbd_valid = 1'b0;
    inhibit   = 1'b0;
    repeat (3) tick();
    chk("reset_ps2_clk", 32'(ps2_clk), 32'd1);
    chk("reset_ps2_data", 32'(ps2_data), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);
    chk("reset_kbd_ready", 32'(kbd_ready), 32'd1);
    n_reset = 1'b1;
    repeat (2) tick();

    // Single frame 0x1C: bit sequence, edge count, total busy time.
    f0 = falls;
    exp_q.push_back(8'h1C);
    push(8'h1C);
    t = 0;
    while (busy !== 1'b1 && t < 100) begin tick(); t++; end
    cyc = 0;
    while (busy === 1'b1 && cyc < 500) begin tick(); cyc++; end
    chk("busy_cycles_1c", 32'(cyc), 32'(24 * D));
    chk("falls_1c", 32'(falls - f0), 32'd11);
    ef = frame_bits(8'h1C);
    chk("bits_1c", 32'(last_bits), 32'(ef));
    drain("f1c");

    // 0x00 then 0xFF back-to-back: GAP, one IDLE cycle, then the first HIGH.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    push(8'h00);
    push(8'hFF);
    drain("b2b");
    chk("b2b_lead_high", 32'(last_lead), 32'(3 * D + 1));
    chk("b2b_parity_ff", 32'(last_bits[9]), 32'd1);

    // Five consecutive offers: the fifth finds the FIFO full and is dropped.
    for (int i = 0; i < 5; i++) five[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_q.push_back(five[i]);
      push(five[i]);
      chk("fill_count", 32'(fifo_count), 32'((i < DEPTH) ? i + 1 : DEPTH));
      chk("fill_ready", 32'(kbd_ready), 32'((i + 1 < DEPTH) ? 1 : 0));
    end
    drain("fill");

    // Push lands on the same edge as the pop: count stays put.
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'hC4);
    push(8'h3A);
    push(8'h6B);
    t = 0;
    while (rx_q.size() == 0 && t < 500) begin tick(); t++; end
    chk("pushpop_first_frame", 32'(rx_q.size()), 32'd1);
    repeat (3) tick();
    chk("pushpop_before", 32'(fifo_count), 32'd2);
    push(8'hC4);
    chk("pushpop_after", 32'(fifo_count), 32'd2);
    drain("pushpop");

    // Inhibit held in IDLE blocks the start.
    f0 = falls;
    inhibit = 1'b1;
    exp_q.push_back(8'h3C);
    push(8'h3C);
    repeat (20) tick();
    chk("idle_inhibit_busy", 32'(busy), 32'd0);
    chk("idle_inhibit_count", 32'(fifo_count), 32'd1);
    chk("idle_inhibit_falls", 32'(falls - f0), 32'd0);
    inhibit = 1'b0;
    drain("idle_inh");

    // Inhibit during data bit 3 of 0xA5: abort, hold, then full retransmission.
    exp_q.push_back(8'hA5);
    push(8'hA5);
    wait_bit(4);
    inhibit = 1'b1;
    tick();
    chk("abort_ps2_clk", 32'(ps2_clk), 32'd1);
    chk("abort_ps2_data", 32'(ps2_data), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_count", 32'(fifo_count), 32'd1);
    repeat (10) tick();
    chk("hold_ps2_clk", 32'(ps2_clk), 32'd1);
    chk("hold_no_frame", 32'(rx_q.size()), 32'd0);
    inhibit = 1'b0;
    drain("abort");

    // Inhibit during the stop bit is ignored; the byte is popped.
    exp_q.push_back(8'h5A);
    push(8'h5A);
    wait_bit(10);
    inhibit = 1'b1;
    tick();
    chk("stop_inhibit_count", 32'(fifo_count), 32'd1);
    drain("stop_inh");
    inhibit = 1'b0;
    tick();

    // Randomized batches against the queue model.
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
      end
      chk("rand_count", 32'(fifo_count), 32'(n));
      drain("rand");
    end

    // Reset during bit 5 with three bytes queued.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_bit(6);
    n_reset = 1'b0;
    #1;
    chk("midreset_ps2_clk", 32'(ps2_clk), 32'd1);
    chk("midreset_ps2_data", 32'(ps2_data), 32'd1);
    chk("midreset_count", 32'(fifo_count), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_ready", 32'(kbd_ready), 32'd1);
    repeat (2) tick();
    n_reset = 1'b1;
    rx_q.delete();
    exp_q.delete();
    f0 = falls;
    repeat (200) tick();
    chk("postreset_falls", 32'(falls - f0), 32'd0);
    chk("postreset_busy", 32'(busy), 32'd0);
    chk("postreset_frames", 32'(rx_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
